down_counter_bank: RTL and testbench

Multi-channel, parametrised successor to the single down counter. It holds CHANNELS independent BIN_LEN-bit down counters that are loaded together by a start strobe and decremented under per-channel enables. It reports per-channel and aggregate terminal count. It can also auto-reload for a programmable number of extra passes. It sits in the MVM control path, where it sequences bit-serial stream lengths for several lanes at once and signals completion to the tile controller.

---
 rtl/down_counter_bank.sv | 134 +++++++++++++
 tb/tb_down_counter_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_bank.sv
// down_counter_bank
// A bank of CHANNELS independent down counters. They are loaded together by a
// start strobe and decremented under per-channel enables. The bank reports
// per-channel and aggregate terminal count. After the first pass it can
// reload the latched initial values for a programmable number of extra passes.
module down_counter_bank #(
    parameter int BIN_LEN  = 8,
    parameter int CHANNELS = 4,
    parameter int PASS_W   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CHANNELS*BIN_LEN-1:0]  count_init,
    input  logic [PASS_W-1:0]            passes,
    input  logic [CHANNELS-1:0]          enable,
    input  logic                         abort,
    output logic [CHANNELS-1:0]          zero,
    output logic                         all_zero,
    output logic [CHANNELS*BIN_LEN-1:0]  count_out,
    output logic                         busy,
    output logic                         pass_done,
    output logic                         done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BIN_LEN-1:0] CNT_ONE  = {{(BIN_LEN-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0]  PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};

    logic [1:0]                  state_r;
    logic [1:0]                  state_s;
    logic [CHANNELS*BIN_LEN-1:0] count_r;
    logic [CHANNELS*BIN_LEN-1:0] count_s;
    logic [CHANNELS*BIN_LEN-1:0] init_r;
    logic [CHANNELS*BIN_LEN-1:0] init_s;
    logic [PASS_W-1:0]           left_r;
    logic [PASS_W-1:0]           left_s;
    logic                        done_r;
    logic                        done_s;
    logic                        pass_done_r;
    logic                        pass_done_s;
    logic [CHANNELS-1:0]         zero_s;
    logic                        all_zero_s;

    // Terminal-count flags, taken straight from the count registers
    always_comb begin
        zero_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            zero_s[i] = (count_r[i*BIN_LEN +: BIN_LEN] == {BIN_LEN{1'b0}});
        end
        all_zero_s = &zero_s;
    end

    // Next-state logic: in RUN, abort wins over reload/finish, which wins over decrement
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        init_s      = init_r;
        left_s      = left_r;
        done_s      = 1'b0;
        pass_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    count_s = count_init;
                    init_s  = count_init;
                    left_s  = passes;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (all_zero_s) begin
                    if (left_r != {PASS_W{1'b0}}) begin
                        count_s     = init_r;
                        left_s      = left_r - PASS_ONE;
                        pass_done_s = 1'b1;
                    end else begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    // A channel already at zero holds there; it never wraps
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (enable[i] && !zero_s[i]) begin
                            count_s[i*BIN_LEN +: BIN_LEN] = count_r[i*BIN_LEN +: BIN_LEN] - CNT_ONE;
                        end else begin
                            count_s[i*BIN_LEN +: BIN_LEN] = count_r[i*BIN_LEN +: BIN_LEN];
                        end
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= {(CHANNELS*BIN_LEN){1'b0}};
            init_r      <= {(CHANNELS*BIN_LEN){1'b0}};
            left_r      <= {PASS_W{1'b0}};
            done_r      <= 1'b0;
            pass_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            init_r      <= init_s;
            left_r      <= left_s;
            done_r      <= done_s;
            pass_done_r <= pass_done_s;
        end
    end

    assign zero      = zero_s;
    assign all_zero  = all_zero_s;
    assign count_out = count_r;
    assign busy      = (state_r == ST_RUN);
    assign done      = done_r;
    assign pass_done = pass_done_r;

endmodule

// File: tb/tb_down_counter_bank.sv
// Self-checking bench for down_counter_bank: directed scenarios followed by
// randomized traffic. Each cycle is checked against a behavioural model.
module tb_down_counter_bank;

    localparam int BL = 8;
    localparam int CH = 4;
    localparam int PW = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_FIN  = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [CH*BL-1:0] count_init;
    logic [PW-1:0]   passes;
    logic [CH-1:0]   enable;
    logic            abort;
    logic [CH-1:0]   zero;
    logic            all_zero;
    logic [CH*BL-1:0] count_out;
    logic            busy;
    logic            pass_done;
    logic            done;

    int vectors    = 0;
    int miscompares = 0;

    // behavioural model state
    int m_cnt [CH];
    int m_init[CH];
    int m_left;
    int m_phase;
    bit m_done;
    bit m_pd;

    down_counter_bank #(.BIN_LEN(BL), .CHANNELS(CH), .PASS_W(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .count_init(count_init),
        .passes    (passes),
        .enable    (enable),
        .abort     (abort),
        .zero      (zero),
        .all_zero  (all_zero),
        .count_out (count_out),
        .busy      (busy),
        .pass_done (pass_done),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs now applied
    task automatic model_edge();
        bit az;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[i] = 0;
                m_init[i] = 0;
            end
            m_left = 0; m_phase = PH_IDLE; m_done = 1'b0; m_pd = 1'b0;
        end else begin
            m_done = 1'b0;
            m_pd   = 1'b0;
            if (m_phase == PH_IDLE) begin
                if (start) begin
                    for (int i = 0; i < CH; i++) begin
                        m_cnt[i]  = int'(count_init[i*BL +: BL]);
                        m_init[i] = m_cnt[i];
                    end
                    m_left  = int'(passes);
                    m_phase = PH_RUN;
                end
            end else if (m_phase == PH_RUN) begin
                az = 1'b1;
                for (int i = 0; i < CH; i++) if (m_cnt[i] != 0) az = 1'b0;
                if (abort) begin
                    m_phase = PH_IDLE;
                end else if (az && m_left > 0) begin
                    for (int i = 0; i < CH; i++) m_cnt[i] = m_init[i];
                    m_left = m_left - 1;
                    m_pd   = 1'b1;
                end else if (az) begin
                    m_phase = PH_FIN;
                    m_done  = 1'b1;
                end else begin
                    for (int i = 0; i < CH; i++)
                        if (enable[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                end
            end else begin
                m_phase = PH_IDLE;
            end
        end
    endtask

    task automatic compare_all();
        logic [CH*BL-1:0] exp_cnt;
        logic [CH-1:0]    exp_zero;
        for (int i = 0; i < CH; i++) begin
            exp_cnt[i*BL +: BL] = m_cnt[i][BL-1:0];
            exp_zero[i]         = (m_cnt[i] == 0);
        end
        check("count_out", 64'(count_out), 64'(exp_cnt));
        check("zero",      64'(zero),      64'(exp_zero));
        check("all_zero",  64'(all_zero),  64'(&exp_zero));
        check("busy",      64'(busy),      64'(m_phase == PH_RUN));
        check("done",      64'(done),      64'(m_done));
        check("pass_done", 64'(pass_done), 64'(m_pd));
    endtask

    task automatic step(input logic rs, input logic st, input logic [CH*BL-1:0] ini,
                        input logic [PW-1:0] ps, input logic [CH-1:0] en, input logic ab);
        reset = rs; start = st; count_init = ini; passes = ps; enable = en; abort = ab;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int done_at;
        int busy_n;
        int pd_n;
        int done_n;
        logic [CH-1:0] en_r;
        logic [CH*BL-1:0] ini_r;

        reset = 1'b1; start = 1'b0; count_init = 32'd0; passes = 4'd0;
        enable = 4'h0; abort = 1'b0;
        for (int i = 0; i < CH; i++) begin m_cnt[i] = 0; m_init[i] = 0; end
        m_left = 0; m_phase = PH_IDLE; m_done = 1'b0; m_pd = 1'b0;

        // reset, including a start strobe while reset is held
        step(1'b1, 1'b0, 32'd0, 4'd0, 4'h0, 1'b0);
        step(1'b1, 1'b1, {8'd9, 8'd8, 8'd7, 8'd6}, 4'd3, 4'hF, 1'b0);
        check("reset_zero", 64'(zero), 64'(4'b1111));
        check("reset_count", 64'(count_out), 64'd0);
        step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);
        step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);

        // basic count {ch0=3, ch1=0, ch2=5, ch3=1}
        step(1'b0, 1'b1, {8'd1, 8'd5, 8'd0, 8'd3}, 4'd0, 4'hF, 1'b0);
        check("zero1_at_load", 64'(zero[1]), 64'd1);
        done_at = 0;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);
            if (done === 1'b1) done_at = k;
        end
        check("done_edge_basic", 64'(done_at), 64'd6);
        step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);

        // same init, ch2 stalled for E2..E4
        step(1'b0, 1'b1, {8'd1, 8'd5, 8'd0, 8'd3}, 4'd0, 4'hF, 1'b0);
        done_at = 0;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            en_r = (k >= 2 && k <= 4) ? 4'hB : 4'hF;
            step(1'b0, 1'b0, 32'd0, 4'd0, en_r, 1'b0);
            if (done === 1'b1) done_at = k;
        end
        check("done_edge_stall", 64'(done_at), 64'd9);
        step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);

        // two extra passes with all channels at 2
        step(1'b0, 1'b1, {8'd2, 8'd2, 8'd2, 8'd2}, 4'd2, 4'hF, 1'b0);
        busy_n = (busy === 1'b1) ? 1 : 0;
        pd_n = 0; done_n = 0;
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);
            if (busy === 1'b1) busy_n++;
            if (pass_done === 1'b1) begin
                pd_n++;
                check("reload_value", 64'(count_out), 64'h02020202);
            end
            if (done === 1'b1) done_n++;
        end
        check("run_cycles", 64'(busy_n), 64'd9);
        check("pass_done_count", 64'(pd_n), 64'd2);
        check("done_count", 64'(done_n), 64'd1);

        // abort while ch2 is at 3
        step(1'b0, 1'b1, {8'd5, 8'd5, 8'd5, 8'd5}, 4'd0, 4'hF, 1'b0);
        step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);
        step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);
        step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b1);
        check("abort_hold_ch2", 64'(count_out[23:16]), 64'd3);
        done_n = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);
            if (done === 1'b1) done_n++;
        end
        check("abort_no_done", 64'(done_n), 64'd0);
        step(1'b0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 4'd0, 4'hF, 1'b0);
        check("restart_load", 64'(count_out), 64'h04030201);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 32'd0, 4'd0, 4'h5, 1'b0);

        // start ignored in RUN, then reset mid-RUN
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'd0, 4'd0, 4'hF, 1'b0);
        step(1'b0, 1'b1, {8'd6, 8'd6, 8'd6, 8'd6}, 4'd1, 4'hF, 1'b0);
        step(1'b0, 1'b1, {8'd1, 8'd1, 8'd1, 8'd1}, 4'd0, 4'hF, 1'b0);
        check("start_ignored_in_run", 64'(count_out), 64'h05050505);
        step(1'b1, 1'b1, {8'd3, 8'd2, 8'd1, 8'd7}, 4'd4, 4'hF, 1'b0);
        check("reset_mid_run_count", 64'(count_out), 64'd0);
        check("reset_mid_run_busy", 64'(busy), 64'd0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++) ini_r[i*BL +: BL] = 8'($urandom_range(0, 6));
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0),
                 ini_r,
                 4'($urandom_range(0, 2)),
                 4'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
